// File: rtl/print_arbiter.sv
// print_arbiter
// Round-robin arbiter sharing one character printer among NREQ requesters.
// A grant is held for a whole message, until the character flagged last is
// accepted by the printer.
// Optional watchdog (macro PRINT_ARBITER_WATCHDOG_EN): reclaims the printer
// after TIMEOUT cycles in which the owner has no valid character.
//
//   state   | meaning
//   --------+-------------------------------------------
//   ST_IDLE | no owner; arbitrate among req_valid
//   ST_XFER | printer locked to r_owner until last/abort
module print_arbiter #(
    parameter int NREQ    = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     pr_valid,
    output logic [DATA_W-1:0]        pr_data,
    input  logic                     pr_ready,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     abort
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {ST_IDLE, ST_XFER} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  w_owner_nxt;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  w_rr_ptr_nxt;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   w_grant_nxt;
    logic              r_abort;
    logic              w_abort_nxt;

    logic              w_pick_found;
    logic [IDX_W-1:0]  w_pick;
    logic [IDX_W:0]    w_scan;
    logic              w_own_valid;
    logic              w_own_last;
    logic              w_xfer;
    logic              w_timeout;

    assign w_own_valid = req_valid[r_owner];
    assign w_own_last  = req_last[r_owner];
    assign w_xfer      = (r_state == ST_XFER) && w_own_valid && pr_ready;

    // Round-robin pick: first valid lane after the last served one, wrapping.
    always_comb begin
        w_pick_found = 1'b0;
        w_pick       = '0;
        w_scan       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
            if (w_scan >= (IDX_W+1)'(NREQ))
                w_scan = w_scan - (IDX_W+1)'(NREQ);
            if (!w_pick_found && req_valid[w_scan[IDX_W-1:0]]) begin
                w_pick_found = 1'b1;
                w_pick       = w_scan[IDX_W-1:0];
            end
        end
    end

`ifdef PRINT_ARBITER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // Count consecutive owner-idle cycles; printer backpressure does not count.
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_XFER) || w_own_valid)
            r_wd_cnt <= '0;
        else
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
    end

    // Fires on the cycle in which the count would reach TIMEOUT.
    assign w_timeout = (r_state == ST_XFER) && !w_own_valid &&
                       (r_wd_cnt == WD_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_rr_ptr <= IDX_W'(NREQ - 1);
            r_grant  <= '0;
            r_abort  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_grant  <= w_grant_nxt;
            r_abort  <= w_abort_nxt;
        end
    end

    // Next-state logic: lock on arbitration, release on last transfer or abort.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_grant_nxt  = r_grant;
        w_abort_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = ST_XFER;
                    w_owner_nxt = w_pick;
                    w_grant_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
                end
            end
            ST_XFER: begin
                if ((w_xfer && w_own_last) || w_timeout) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = r_owner;
                    w_grant_nxt  = '0;
                    w_abort_nxt  = w_timeout;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Output mux: only the owner's lane reaches the printer.
    always_comb begin
        req_ready = '0;
        pr_valid  = 1'b0;
        pr_data   = '0;
        if (r_state == ST_XFER) begin
            pr_valid           = w_own_valid;
            pr_data            = req_data[int'(r_owner)*DATA_W +: DATA_W];
            req_ready[r_owner] = pr_ready;
        end
    end

    assign grant = r_grant;
    assign busy  = (r_state == ST_XFER);
    assign abort = r_abort;

endmodule

// File: tb/tb_print_arbiter.sv
// Self-checking bench for print_arbiter: lane drivers fed from per-lane
// queues, expected printer output kept in a scoreboard in predicted order.
module tb_print_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    typedef struct {
        int         lane;
        logic [7:0] ch;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    req_ready;
    logic               pr_valid;
    logic [DW-1:0]      pr_data;
    logic               pr_ready;
    logic [NREQ-1:0]    grant;
    logic               busy;
    logic               abort;

    logic [8:0]      lane_q [NREQ][$];
    exp_t            sb[$];
    logic [NREQ-1:0] gtrace[$];

    logic [NREQ-1:0] s_grant;
    logic [NREQ-1:0] s_req_ready;
    logic            s_busy;
    logic            s_abort;
    logic            s_pr_valid;
    logic [DW-1:0]   s_pr_data;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    print_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .pr_valid  (pr_valid),
        .pr_data   (pr_data),
        .pr_ready  (pr_ready),
        .grant     (grant),
        .busy      (busy),
        .abort     (abort)
    );

    // One clock per iteration: drive lane heads, sample mid-cycle, score transfers.
    task automatic step(input int n);
        exp_t e;
        for (int c = 0; c < n; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (lane_q[i].size() > 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = lane_q[i][0][7:0];
                    req_last[i]          = lane_q[i][0][8];
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*DW +: DW] = '0;
                    req_last[i]          = 1'b0;
                end
            end
            @(negedge clk);
            s_grant     = grant;
            s_req_ready = req_ready;
            s_busy      = busy;
            s_abort     = abort;
            s_pr_valid  = pr_valid;
            s_pr_data   = pr_data;
            gtrace.push_back(grant);
            if (pr_valid && pr_ready) begin
                n_total++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: got grant=%b data=%h, required no transfer", grant, pr_data);
                end else begin
                    e = sb.pop_front();
                    if (grant !== (NREQ'(1) << e.lane) || pr_data !== e.ch)
                        $display("FAIL sb_xfer: got grant=%b data=%h, required grant=%b data=%h",
                                 grant, pr_data, NREQ'(1) << e.lane, e.ch);
                    else
                        n_pass++;
                end
            end
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i])
                    void'(lane_q[i].pop_front());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_msg(input int lane, input string s);
        exp_t e;
        for (int k = 0; k < s.len(); k++) begin
            lane_q[lane].push_back({(k == s.len() - 1), s[k]});
            e.lane = lane;
            e.ch   = s[k];
            sb.push_back(e);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        pr_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) lane_q[i].delete();
        sb.delete();
        step(1);
        rst = 1'b0;
        gtrace.delete();
    endtask

    task automatic test_reset();
        do_reset();
        step(1);
        n_total += 6;
        if (s_grant !== '0) $display("FAIL rst_grant: got %b, required 0", s_grant); else n_pass++;
        if (s_busy !== 1'b0) $display("FAIL rst_busy: got %b, required 0", s_busy); else n_pass++;
        if (s_abort !== 1'b0) $display("FAIL rst_abort: got %b, required 0", s_abort); else n_pass++;
        if (s_pr_valid !== 1'b0) $display("FAIL rst_pr_valid: got %b, required 0", s_pr_valid); else n_pass++;
        if (s_pr_data !== '0) $display("FAIL rst_pr_data: got %h, required 0", s_pr_data); else n_pass++;
        if (s_req_ready !== '0) $display("FAIL rst_req_ready: got %b, required 0", s_req_ready); else n_pass++;
    endtask

    task automatic test_two_messages();
        logic [NREQ-1:0] exp_tr [9] = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};
        do_reset();
        load_msg(1, "abc");
        load_msg(3, "xyz");
        step(9);
        for (int k = 0; k < 9; k++) begin
            n_total++;
            if (gtrace[k] !== exp_tr[k])
                $display("FAIL two_msg_grant[%0d]: got %b, required %b", k, gtrace[k], exp_tr[k]);
            else n_pass++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL two_msg_drain: got %0d left, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [NREQ-1:0] exp_g;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < NREQ; i++)
                load_msg(i, (r == 0) ? "A" : (r == 1) ? "B" : "C");
        step(25);
        for (int k = 0; k < 25; k++) begin
            exp_g = (k % 2 == 0) ? '0 : (NREQ'(1) << ((k / 2) % NREQ));
            n_total++;
            if (gtrace[k] !== exp_g)
                $display("FAIL rr_grant[%0d]: got %b, required %b", k, gtrace[k], exp_g);
            else n_pass++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL rr_drain: got %0d left, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        do_reset();
        load_msg(2, "pqr");
        step(2);
        pr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            n_total += 4;
            if (s_pr_data !== 8'h71) $display("FAIL stall_data[%0d]: got %h, required 71", k, s_pr_data); else n_pass++;
            if (s_pr_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b, required 1", k, s_pr_valid); else n_pass++;
            if (s_req_ready !== '0) $display("FAIL stall_ready[%0d]: got %b, required 0", k, s_req_ready); else n_pass++;
            if (s_abort !== 1'b0) $display("FAIL stall_abort[%0d]: got %b, required 0", k, s_abort); else n_pass++;
        end
        pr_ready = 1'b1;
        step(3);
        n_total += 2;
        if (sb.size() != 0) $display("FAIL stall_drain: got %0d left, required 0", sb.size()); else n_pass++;
        if (s_busy !== 1'b0) $display("FAIL stall_busy_end: got %b, required 0", s_busy); else n_pass++;
    endtask

    task automatic test_reset_mid_message();
        logic [NREQ-1:0] exp_tr [4] = '{4'h0, 4'h1, 4'h1, 4'h0};
        do_reset();
        load_msg(0, "abcde");
        step(3);
        rst      = 1'b1;
        pr_ready = 1'b0;
        step(1);
        rst = 1'b0;
        lane_q[0].delete();
        n_total++;
        if (sb.size() != 3) $display("FAIL rstmid_sent: got %0d left, required 3", sb.size()); else n_pass++;
        sb.delete();
        pr_ready = 1'b1;
        step(1);
        n_total += 3;
        if (s_grant !== '0) $display("FAIL rstmid_grant: got %b, required 0", s_grant); else n_pass++;
        if (s_busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", s_busy); else n_pass++;
        if (s_pr_valid !== 1'b0) $display("FAIL rstmid_pr_valid: got %b, required 0", s_pr_valid); else n_pass++;
        load_msg(0, "hi");
        gtrace.delete();
        step(4);
        for (int k = 0; k < 4; k++) begin
            n_total++;
            if (gtrace[k] !== exp_tr[k])
                $display("FAIL rstmid_regrant[%0d]: got %b, required %b", k, gtrace[k], exp_tr[k]);
            else n_pass++;
        end
        n_total++;
        if (sb.size() != 0) $display("FAIL rstmid_drain: got %0d left, required 0", sb.size()); else n_pass++;
    endtask

    task automatic test_no_preempt();
        exp_t e;
        logic seen1;
        do_reset();
        for (int k = 0; k < 30; k++) begin
            lane_q[0].push_back({1'b0, 8'(8'h40 + k)});
            e.lane = 0;
            e.ch   = 8'(8'h40 + k);
            sb.push_back(e);
        end
        lane_q[1].push_back({1'b1, 8'h5a});
        seen1 = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step(1);
            if (s_grant[1] || s_req_ready[1]) seen1 = 1'b1;
        end
        n_total += 2;
        if (seen1 !== 1'b0) $display("FAIL starve_lane1: got grant/ready on lane 1, required none"); else n_pass++;
        if (sb.size() != 6) $display("FAIL starve_count: got %0d left, required 6", sb.size()); else n_pass++;
    endtask

`ifdef PRINT_ARBITER_WATCHDOG_EN
    task automatic test_watchdog();
        exp_t e;
        logic early;
        do_reset();
        lane_q[1].push_back({1'b0, 8'h31});
        e.lane = 1; e.ch = 8'h31; sb.push_back(e);
        step(2);
        early = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(1);
            if (s_abort) early = 1'b1;
        end
        load_msg(2, "2");
        load_msg(0, "0");
        step(1);
        n_total += 4;
        if (early !== 1'b0) $display("FAIL wd_early_abort: got abort before timeout, required none"); else n_pass++;
        if (s_abort !== 1'b1) $display("FAIL wd_abort: got %b, required 1", s_abort); else n_pass++;
        if (s_busy !== 1'b0) $display("FAIL wd_busy: got %b, required 0", s_busy); else n_pass++;
        step(1);
        if (s_grant !== 4'b0100) $display("FAIL wd_next_grant: got %b, required 0100", s_grant); else n_pass++;
        step(3);
        n_total++;
        if (sb.size() != 0) $display("FAIL wd_drain: got %0d left, required 0", sb.size()); else n_pass++;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        pr_ready  = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        test_reset();
        test_two_messages();
        test_round_robin();
        test_backpressure();
        test_reset_mid_message();
        test_no_preempt();
`ifdef PRINT_ARBITER_WATCHDOG_EN
        test_watchdog();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/print_arbiter.md
# print_arbiter

Round-robin arbiter that shares the single terminal character printer among the UI requesters inside the internal processing layer: introduction screen, ALU, CPU and matrix-bench sections. Each requester streams a message one character at a time over a valid/ready handshake. The arbiter locks the printer to one requester for a whole message, which ends at the character flagged `last`, so messages never interleave on the terminal. An optional watchdog reclaims the printer from a requester that stalls mid-message.

## Interface
Parameters:
- `NREQ`, 4, number of requesters; index 0 intro, 1 ALU, 2 CPU, 3 bench
- `DATA_W`, 8, character width (ASCII)
- `TIMEOUT`, 1023, stall cycles before forced release (watchdog builds only)

Ports:
- `clk`  in  1  single system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  NREQ  requester i has a character on its lane
- `req_data`  in  NREQ*DATA_W  packed characters; lane i is `[i*DATA_W +: DATA_W]`
- `req_last`  in  NREQ  lane i's current character ends its message
- `req_ready`  out  NREQ  lane i's character is accepted this cycle
- `pr_valid`  out  1  character presented to the printer
- `pr_data`  out  DATA_W  character to the printer
- `pr_ready`  in  1  printer accepts the character this cycle
- `grant`  out  NREQ  one-hot current owner; all zero when idle
- `busy`  out  1  a message is in progress (state XFER)
- `abort`  out  1  one-cycle pulse when the watchdog forces a release

## Operation
- States:
  - IDLE: no owner.
  - XFER: owner locked.
- IDLE:
  - If any `req_valid` is set, select the first set bit scanning from `(rr_ptr+1) mod NREQ` upward with wrap-around.
  - Register that bit as `owner` and go to XFER.
  - If no `req_valid` is set, stay in IDLE.
- XFER:
  - `pr_valid = req_valid[owner]` and `pr_data = lane[owner]` (combinational mux).
  - `req_ready[owner] = pr_ready`. All other `req_ready` bits are 0.
  - A transfer occurs when `pr_valid && pr_ready`.
  - On a transfer with `req_last[owner]=1`: set `rr_ptr <= owner`, go to IDLE.
- Outside XFER: `pr_valid=0`, `pr_data=0`, `req_ready=0`.
- Lane discipline: once a requester asserts `req_valid`, it must hold valid, data and last stable until accepted. The arbiter does not check this.
- Non-owners wait. Their valid is ignored until the next IDLE arbitration.
- Simultaneous requests resolve by round-robin. The most recently served requester has the lowest priority at the next arbitration.
- A message of exactly one character (`last=1` on the first character) is legal and costs one XFER cycle if the printer is ready.
- `pr_ready` asserted without `pr_valid` has no effect.

## Timing
- Reset values:
  - State IDLE, `owner=0`, `rr_ptr=NREQ-1` (requester 0 wins the first arbitration).
  - `grant=0`, `busy=0`, `abort=0`, `pr_valid=0`, `pr_data=0`, `req_ready=0`.
  - Watchdog counter 0.
- Reset asserted mid-message: the message is dropped with no further handshakes, and all of the reset values above apply from the next edge.
- Arbitration latency: valid seen in IDLE at edge N gives `grant`/`busy` high after edge N. The earliest first transfer is in cycle N+1.
- Back-to-back messages: the last transfer in cycle M returns to IDLE after edge M. The next grant appears after edge M+1, giving exactly one idle cycle between messages.
- Throughput within a message: one character per cycle while `pr_ready=1` and the owner holds valid.
- `grant` and `busy` are registered. `req_ready`, `pr_valid` and `pr_data` are combinational from state, owner and the inputs.

## Configuration
- `PRINT_ARBITER_WATCHDOG_EN` defined:
  - In XFER, a counter increments each cycle the owner's `req_valid=0`. It clears on any owner valid and on entry to XFER.
  - Printer backpressure (`pr_ready=0`) does not count.
  - When the counter reaches `TIMEOUT`: pulse `abort` for one cycle, set `rr_ptr <= owner`, go to IDLE.
- Macro undefined: no counter is built, `abort` is tied to 0, and an owner may hold the printer indefinitely.

## Test plan
- Reset, then requesters 1 and 3 each raise valid with a 3-character message ("ab" plus a `last` char) → 1 is granted first; `pr_data` = 'a','b', then last char on consecutive cycles; one idle cycle; then 3 is granted.
- All four requesters request continuously with single-character messages → grant order after reset is 0,1,2,3,0,…; each grant lasts 1 cycle with an idle cycle between grants.
- Owner 2 is sending; hold `pr_ready=0` for 5 cycles → `pr_data` holds steady, `req_ready[2]=0` during the stall, no character is lost or duplicated, and no `abort` is raised even in watchdog builds.
- Watchdog build with `TIMEOUT=8`: owner 1 sends 1 character, then drops valid → `abort` pulses 8 cycles after the drop, `busy` falls, and the next arbitration favours 2.
- Assert `rst` for 1 cycle while owner 0 is mid-message → the next cycle shows `grant=0`, `busy=0`, `pr_valid=0`; a subsequent request from 0 is granted normally.
- Requester 0 holds valid but never asserts `last`, while 1 waits (non-watchdog build) → 1 is never granted and `req_ready[1]` stays 0 throughout.
